// File: rtl/fxp_pkg.sv
// fxp_pkg -- shared types and arithmetic helpers for the fixed-point
// multiplier pipeline.
//   rnd_mode_e      : per-beat rounding mode (half-up or truncate/floor)
//   fxp_wide_t      : signed working width, wide enough for a 2N-bit
//                     product plus the rounding increment for N <= 16
//   fxp_round_shift : optional +2^(F-1), then arithmetic shift right by F
//   fxp_ovf         : true when a value lies outside the N-bit signed range
package fxp_pkg;

    typedef enum logic {
        RND_HALF_UP = 1'b0,
        RND_TRUNC   = 1'b1
    } rnd_mode_e;

    // 2*16 product bits plus one headroom bit so the rounding add never wraps.
    localparam int FXP_WW = 33;
    typedef logic signed [FXP_WW-1:0] fxp_wide_t;

    function automatic fxp_wide_t fxp_round_shift(input fxp_wide_t p,
                                                  input int        f,
                                                  input rnd_mode_e m);
        fxp_wide_t t;
        t = p;
        if (m == RND_HALF_UP)
            t = p + (fxp_wide_t'(1) <<< (f - 1));
        return t >>> f;
    endfunction

    function automatic logic fxp_ovf(input fxp_wide_t v, input int n);
        fxp_wide_t lim;
        lim = fxp_wide_t'(1) <<< (n - 1);
        return (v >= lim) || (v < -lim);
    endfunction

endpackage

// File: rtl/fxp_round_sat.sv
// fxp_round_sat -- combinational round + saturate for one lane.
//   i_prod : full-precision signed product, 2N bits with 2F fractional bits
//   i_mode : rounding mode carried with the beat
//   o_y    : signed N-bit result with F fractional bits
//   o_sat  : result was clamped to the N-bit range
module fxp_round_sat
    import fxp_pkg::*;
#(
    parameter int N = 8,
    parameter int F = 7
) (
    input  logic [2*N-1:0] i_prod,
    input  rnd_mode_e      i_mode,
    output logic [N-1:0]   o_y,
    output logic           o_sat
);

    localparam logic [N-1:0] Y_MAX = {1'b0, {(N-1){1'b1}}};
    localparam logic [N-1:0] Y_MIN = {1'b1, {(N-1){1'b0}}};

    fxp_wide_t w_ext;
    fxp_wide_t w_shift;
    logic      w_ovf;

    // Casting a signed operand to the wider signed type sign-extends it.
    assign w_ext   = fxp_wide_t'($signed(i_prod));
    assign w_shift = fxp_round_shift(w_ext, F, i_mode);
    assign w_ovf   = fxp_ovf(w_shift, N);

    assign o_y   = !w_ovf ? w_shift[N-1:0]
                          : (w_shift[FXP_WW-1] ? Y_MIN : Y_MAX);
    assign o_sat = w_ovf;

endmodule

// File: rtl/fxp_mul_pipe.sv
// fxp_mul_pipe -- LANES-wide signed fixed-point multiplier, 3 register stages
// behind one valid/ready handshake.
//   clk, rst_n         : clock, async active-low reset
//   in_valid/in_ready  : input handshake; in_a/in_b packed lane i at [i*N +: N]
//   in_rnd             : 0 round-half-up, 1 truncate; travels with the beat
//   out_valid/out_ready: output handshake; out_y packed like the inputs
//   out_sat            : per-lane clamp flags for the beat on out_y
//   sat_cnt, sat_clr   : saturating count of accepted beats with any clamp,
//                        synchronous clear (clear wins over increment)
// Pipeline: S1 = operands + mode, S2 = full products, S3 = rounded result.
module fxp_mul_pipe
    import fxp_pkg::*;
#(
    parameter int N     = 8,
    parameter int F     = 7,
    parameter int LANES = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [LANES*N-1:0] in_a,
    input  logic [LANES*N-1:0] in_b,
    input  logic               in_rnd,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [LANES*N-1:0] out_y,
    output logic [LANES-1:0]   out_sat,
    output logic [15:0]        sat_cnt,
    input  logic               sat_clr
);

    logic [3:1]                  r_vld;
    logic                        w_ld1, w_ld2, w_ld3;
    logic [LANES-1:0][N-1:0]     r_a, r_b;
    rnd_mode_e                   r_rnd1, r_rnd2;
    logic [LANES-1:0][2*N-1:0]   w_prod, r_prod;
    logic [LANES-1:0][N-1:0]     w_y, r_y;
    logic [LANES-1:0]            w_sat, r_sat;
    logic [15:0]                 r_sat_cnt;
    logic                        w_out_hs;

    // A stage may load when it is empty or its content moves on this cycle.
    // The chain starts at out_ready, so in_ready never depends on in_valid.
    assign w_ld3    = !r_vld[3] || out_ready;
    assign w_ld2    = !r_vld[2] || w_ld3;
    assign w_ld1    = !r_vld[1] || w_ld2;
    assign in_ready = w_ld1;
    assign w_out_hs = r_vld[3] && out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vld <= '0;
        end else begin
            if (w_ld1) r_vld[1] <= in_valid;
            if (w_ld2) r_vld[2] <= r_vld[1];
            if (w_ld3) r_vld[3] <= r_vld[2];
        end
    end

    // Data registers only capture real beats; bubbles leave them untouched.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a    <= '0;
            r_b    <= '0;
            r_rnd1 <= RND_HALF_UP;
        end else if (w_ld1 && in_valid) begin
            r_a    <= in_a;
            r_b    <= in_b;
            r_rnd1 <= rnd_mode_e'(in_rnd);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_prod <= '0;
            r_rnd2 <= RND_HALF_UP;
        end else if (w_ld2 && r_vld[1]) begin
            r_prod <= w_prod;
            r_rnd2 <= r_rnd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_y   <= '0;
            r_sat <= '0;
        end else if (w_ld3 && r_vld[2]) begin
            r_y   <= w_y;
            r_sat <= w_sat;
        end
    end

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        // Both operands widened as signed first so the 2N-bit product is exact.
        assign w_prod[g] = (2*N)'($signed(r_a[g])) * (2*N)'($signed(r_b[g]));

        fxp_round_sat #(
            .N (N),
            .F (F)
        ) u_round_sat (
            .i_prod (r_prod[g]),
            .i_mode (r_rnd2),
            .o_y    (w_y[g]),
            .o_sat  (w_sat[g])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_sat_cnt <= '0;
        else if (sat_clr)
            r_sat_cnt <= '0;
        else if (w_out_hs && (|r_sat) && (r_sat_cnt != 16'hFFFF))
            r_sat_cnt <= r_sat_cnt + 16'd1;
    end

    assign out_valid = r_vld[3];
    assign out_y     = r_y;
    assign out_sat   = r_sat;
    assign sat_cnt   = r_sat_cnt;

endmodule

// File: doc/fxp_mul_pipe.md
FXP_MUL_PIPE -- requirements
Module: fxp_mul_pipe

Interface
REQ-001 SHALL have parameter N, default 8, operand/result width in bits (4..16).
REQ-002 SHALL have parameter F, default 7, fractional bits of operands and result (1..N-1).
REQ-003 SHALL have parameter LANES, default 4, independent multiplier lanes sharing one handshake.
REQ-004 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-005 SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-006 SHALL have port in_valid  input  1  input beat present.
REQ-007 SHALL have port in_ready  output  1  input beat accepted when in_valid && in_ready.
REQ-008 SHALL have port in_a  input  LANES*N  signed Q(N-F).F operands, lane i at bits [i*N +: N].
REQ-009 SHALL have port in_b  input  LANES*N  signed operands, same packing.
REQ-010 SHALL have port in_rnd  input  1  per-beat mode: 0 round-half-up, 1 truncate (floor).
REQ-011 SHALL have port out_valid  output  1  result beat present.
REQ-012 SHALL have port out_ready  input  1  downstream accepts when out_valid && out_ready.
REQ-013 SHALL have port out_y  output  LANES*N  signed results, same packing.
REQ-014 SHALL have port out_sat  output  LANES  per-lane flag: that lane's result was clamped.
REQ-015 SHALL have port sat_cnt  output  16  count of accepted output beats with any out_sat bit set.
REQ-016 SHALL have port sat_clr  input  1  synchronous clear of sat_cnt.

Function
REQ-017 SHALL implement 3 register stages: S1 captures a, b, rnd; S2 holds full 2N-bit signed product per lane; S3 holds rounded, saturated result plus sat flags.
REQ-018 SHALL give latency of exactly 3 cycles from input handshake to out_valid when out_ready is held high.
REQ-019 SHALL sustain one beat per cycle throughput when out_ready is high.
REQ-020 SHALL advance stage k when it is empty or stage k+1 advances in the same cycle; bubbles collapse.
REQ-021 SHALL drive in_ready = !v1 || adv1 combinationally; no combinational path from in_valid to in_ready.
REQ-022 SHALL hold out_y, out_sat, out_valid stable while out_valid && !out_ready.
REQ-023 SHALL compute product with full 2N-bit signed precision (2F fractional bits).
REQ-024 SHALL, for rnd=0, add 2^(F-1) then arithmetic-shift right by F; for rnd=1, arithmetic-shift right by F only.
REQ-025 SHALL clamp the shifted value to [-2^(N-1), 2^(N-1)-1] and set that lane's sat flag iff clamping occurred.
REQ-026 SHALL carry rnd with its beat so mixed-mode back-to-back beats are processed independently.
REQ-027 SHALL increment sat_cnt on each output handshake where |out_sat != 0, saturating at 16'hFFFF.
REQ-028 SHALL give sat_clr priority over a simultaneous increment (result 0).

Reset
REQ-029 SHALL clear all stage valid bits, out_valid=0, out_y=0, out_sat=0, sat_cnt=0 while rst_n=0, and in_ready SHALL evaluate 1 after reset release.
REQ-030 SHALL discard all in-flight beats on reset mid-operation; no beat emerges after release without a new input handshake.

Structure
REQ-031 SHALL place shared round/saturate functions and enum rnd_mode_e {RND_HALF_UP, RND_TRUNC} in package fxp_pkg.
REQ-032 SHALL instantiate LANES copies of sub-module fxp_round_sat (combinational: 2N-bit product, mode -> N-bit result, sat flag) between S2 and S3.
REQ-033 SHALL keep handshake/valid control in one place, shared by all lanes.

Verification (N=8, F=7, LANES=4)
REQ-034 Lane0 a=0x40, b=0x40, rnd=0 -> y=0x20, sat=0, out_valid exactly 3 cycles after accept.
REQ-035 Lane1 a=0x80, b=0x80 -> y=0x7F, sat[1]=1, sat_cnt 0->1 on output handshake.
REQ-036 a=0x01, b=0x40: rnd=0 -> y=0x01; rnd=1 -> y=0x00; a=0xFF, b=0x40: rnd=0 -> 0x00, rnd=1 -> 0xFF, issued back-to-back.
REQ-037 Stream 8 beats, out_ready low cycles 3-6 -> in_ready drops after 3 beats buffered, no loss/duplication, order preserved, out_y stable while stalled.
REQ-038 rst_n low with 3 beats in flight -> out_valid=0 immediately, no stale output after release; sat_clr coincident with saturating handshake -> sat_cnt=0.
